// File: rtl/segment_uop_scheduler.sv
// Segmented vector memory op sequencer: splits one op into (element, field)
// scalar micro-ops in element-major order, throttles with a credit counter and
// reports a single completion carrying the first faulting element.
module segment_uop_scheduler #(
  parameter int unsigned VlWidth        = 16,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_valid_i,
  output logic               start_ready_o,
  input  logic [VlWidth-1:0] vstart_i,
  input  logic [VlWidth-1:0] vl_i,
  input  logic [2:0]         nf_i,
  input  logic [4:0]         vd_i,
  output logic               uop_valid_o,
  input  logic               uop_ready_i,
  output logic [VlWidth-1:0] uop_elem_o,
  output logic [2:0]         uop_field_o,
  output logic [4:0]         uop_vd_o,
  output logic               uop_last_o,
  input  logic               uop_resp_valid_i,
  input  logic               uop_resp_exc_i,
  output logic               done_valid_o,
  output logic               done_exc_o,
  output logic [VlWidth-1:0] done_vstart_o,
  output logic               busy_o
);

  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MaxCred = CW'(MaxOutstanding);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [VlWidth-1:0] vl_q, vl_d;
  logic [2:0]         nf_q, nf_d;
  logic [4:0]         vd_q, vd_d;
  logic [VlWidth-1:0] ielem_q, ielem_d, relem_q, relem_d;
  logic [2:0]         ifield_q, ifield_d, rfield_q, rfield_d;
  logic [CW-1:0]      cred_q, cred_d;
  logic               exc_q, exc_d;
  logic [VlWidth-1:0] exc_vs_q, exc_vs_d;

  logic issue_ok, fire, resp_ok, new_exc, is_last;

  // Issue eligibility depends only on registered state, never on uop_ready_i.
  assign issue_ok = (state_q == ISSUE) && (cred_q < MaxCred) && !exc_q;
  assign fire     = issue_ok && uop_ready_i;
  // A response with no credit outstanding is a protocol error and is dropped.
  assign resp_ok  = uop_resp_valid_i && (cred_q != '0);
  assign new_exc  = resp_ok && uop_resp_exc_i && !exc_q;
  assign is_last  = (ielem_q == vl_q - VlWidth'(1)) && (ifield_q == nf_q);

  // Next-state: FSM, issue/response walkers, credits and exception capture.
  always_comb begin
    state_d  = state_q;
    vl_d     = vl_q;
    nf_d     = nf_q;
    vd_d     = vd_q;
    ielem_d  = ielem_q;
    ifield_d = ifield_q;
    relem_d  = relem_q;
    rfield_d = rfield_q;
    cred_d   = cred_q;
    exc_d    = exc_q;
    exc_vs_d = exc_vs_q;

    if (state_q == ISSUE || state_q == DRAIN) begin
      if (fire) begin
        if (ifield_q == nf_q) begin
          ifield_d = '0;
          ielem_d  = ielem_q + VlWidth'(1);
        end else begin
          ifield_d = ifield_q + 3'd1;
        end
      end
      if (resp_ok) begin
        if (rfield_q == nf_q) begin
          rfield_d = '0;
          relem_d  = relem_q + VlWidth'(1);
        end else begin
          rfield_d = rfield_q + 3'd1;
        end
      end
      if (new_exc) begin
        exc_d    = 1'b1;
        exc_vs_d = relem_q;
      end
      case ({fire, resp_ok})
        2'b10:   cred_d = cred_q + CW'(1);
        2'b01:   cred_d = cred_q - CW'(1);
        default: cred_d = cred_q;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start_valid_i) begin
          vl_d     = vl_i;
          nf_d     = nf_i;
          vd_d     = vd_i;
          ielem_d  = vstart_i;
          ifield_d = '0;
          relem_d  = vstart_i;
          rfield_d = '0;
          cred_d   = '0;
          exc_d    = 1'b0;
          exc_vs_d = '0;
          state_d  = (vstart_i < vl_i) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if ((fire && is_last) || exc_q || new_exc) state_d = DRAIN;
      end
      DRAIN: begin
        if (cred_q == '0 || (cred_q == CW'(1) && resp_ok)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any op without a completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      vl_q     <= '0;
      nf_q     <= '0;
      vd_q     <= '0;
      ielem_q  <= '0;
      ifield_q <= '0;
      relem_q  <= '0;
      rfield_q <= '0;
      cred_q   <= '0;
      exc_q    <= 1'b0;
      exc_vs_q <= '0;
    end else begin
      state_q  <= state_d;
      vl_q     <= vl_d;
      nf_q     <= nf_d;
      vd_q     <= vd_d;
      ielem_q  <= ielem_d;
      ifield_q <= ifield_d;
      relem_q  <= relem_d;
      rfield_q <= rfield_d;
      cred_q   <= cred_d;
      exc_q    <= exc_d;
      exc_vs_q <= exc_vs_d;
    end
  end

  assign start_ready_o = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign uop_valid_o   = issue_ok;
  assign uop_elem_o    = ielem_q;
  assign uop_field_o   = ifield_q;
  assign uop_vd_o      = vd_q + {2'b00, ifield_q};
  assign uop_last_o    = (state_q == ISSUE) && is_last;
  assign done_valid_o  = (state_q == DONE);
  assign done_exc_o    = (state_q == DONE) && exc_q;
  assign done_vstart_o = ((state_q == DONE) && exc_q) ? exc_vs_q : '0;

`ifndef SYNTHESIS
  // Backend must never answer more micro-ops than were issued.
  always_ff @(posedge clk_i) begin
    if (rst_ni && uop_resp_valid_i)
      assert (cred_q != '0) else $error("segment_uop_scheduler: response with no outstanding micro-op");
  end
`endif

endmodule

// File: tb/tb_segment_uop_scheduler.sv
// Directed bench for segment_uop_scheduler: expected micro-ops are queued when
// an op is started and compared as the DUT fires them; responses are replayed
// from a per-fire due-cycle queue.
module tb_segment_uop_scheduler;

  localparam int VW = 16;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [VW-1:0] vstart = '0, vl = '0;
  logic [2:0]    nf = '0;
  logic [4:0]    vd = '0;
  logic          uop_valid, uop_ready = 1'b0;
  logic [VW-1:0] uop_elem;
  logic [2:0]    uop_field;
  logic [4:0]    uop_vd;
  logic          uop_last;
  logic          resp_valid = 1'b0, resp_exc = 1'b0;
  logic          done_valid, done_exc_o;
  logic [VW-1:0] done_vstart;
  logic          busy;

  segment_uop_scheduler #(.VlWidth(VW), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .start_valid_i(start_valid), .start_ready_o(start_ready),
    .vstart_i(vstart), .vl_i(vl), .nf_i(nf), .vd_i(vd),
    .uop_valid_o(uop_valid), .uop_ready_i(uop_ready),
    .uop_elem_o(uop_elem), .uop_field_o(uop_field), .uop_vd_o(uop_vd), .uop_last_o(uop_last),
    .uop_resp_valid_i(resp_valid), .uop_resp_exc_i(resp_exc),
    .done_valid_o(done_valid), .done_exc_o(done_exc_o), .done_vstart_o(done_vstart),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int elem; int field; int vd; int last; } uop_t;
  uop_t sb[$];
  int   due[$];

  int cyc, checks, errors;
  int fires, first_fire, last_fire, nresp, exc_at, lat, acc_cyc;
  int done_cnt, done_cyc, done_exc, done_vs;
  bit auto_resp, force_resp;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive response, score any fire and done, advance past the edge.
  task automatic tick();
    uop_t e;
    resp_valid = 1'b0;
    resp_exc   = 1'b0;
    if (due.size() > 0 && (force_resp || (auto_resp && due[0] <= cyc))) begin
      void'(due.pop_front());
      resp_valid = 1'b1;
      nresp++;
      resp_exc = (nresp == exc_at);
    end
    if (uop_valid && uop_ready) begin
      fires++;
      if (fires == 1) first_fire = cyc;
      last_fire = cyc;
      due.push_back(cyc + lat);
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_uop: observed elem %0d field %0d expected none", uop_elem, uop_field);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("uop_elem",  uop_elem,  e.elem);
        check("uop_field", uop_field, e.field);
        check("uop_vd",    uop_vd,    e.vd);
        check("uop_last",  uop_last,  e.last);
      end
    end
    if (done_valid) begin
      done_cnt++;
      done_cyc = cyc;
      done_exc = done_exc_o;
      done_vs  = done_vstart;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_op(int s, int l, int f, int d);
    uop_t e;
    fires = 0; nresp = 0; done_cnt = 0;
    for (int el = s; el < l; el++)
      for (int fi = 0; fi <= f; fi++) begin
        e.elem = el; e.field = fi; e.vd = (d + fi) % 32;
        e.last = (el == l - 1 && fi == f) ? 1 : 0;
        sb.push_back(e);
      end
    vstart = VW'(s); vl = VW'(l); nf = 3'(f); vd = 5'(d);
    check("start_ready", start_ready, 1);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt, 1);
    check("done_one_cycle", done_valid, 0);
    repeat (2) tick();
    check("done_count", done_cnt, 1);
  endtask

  task automatic check_idle(string tag);
    check({tag, "_start_ready"}, start_ready, 1);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_uop_valid"},   uop_valid, 0);
    check({tag, "_uop_last"},    uop_last, 0);
    check({tag, "_uop_elem"},    uop_elem, 0);
    check({tag, "_uop_field"},   uop_field, 0);
    check({tag, "_uop_vd"},      uop_vd, 0);
    check({tag, "_done_valid"},  done_valid, 0);
    check({tag, "_done_exc"},    done_exc_o, 0);
    check({tag, "_done_vstart"}, done_vstart, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    uop_ready = 1'b1;

    // 1: basic two-element, two-field op, responses two cycles after fire
    lat = 2; auto_resp = 1; exc_at = 0;
    start_op(0, 2, 1, 8);
    wait_done(40);
    check("t1_fires", fires, 4);
    check("t1_done_exc", done_exc, 0);
    check("t1_done_vstart", done_vs, 0);
    check("t1_sb_empty", sb.size(), 0);

    // 2: credit limit with no responses, then one response frees one slot
    auto_resp = 0;
    start_op(0, 8, 0, 0);
    repeat (8) tick();
    check("t2_fires_capped", fires, MO);
    check("t2_valid_low", uop_valid, 0);
    force_resp = 1;
    tick();
    force_resp = 0;
    repeat (4) tick();
    check("t2_fires_after_resp", fires, MO + 1);
    auto_resp = 1;
    wait_done(60);
    check("t2_fires_total", fires, 8);
    check("t2_done_exc", done_exc, 0);
    check("t2_sb_empty", sb.size(), 0);

    // 3: exception on 5th response (elem 4, field 1); fire of response k lands
    // with fire k+2, so fires 1..7 occur and 2 expected micro-ops never issue
    exc_at = 5;
    start_op(3, 6, 2, 4);
    wait_done(60);
    check("t3_fires", fires, 7);
    check("t3_done_exc", done_exc, 1);
    check("t3_done_vstart", done_vs, 4);
    check("t3_sb_left", sb.size(), 2);
    check("t3_resp_drained", due.size(), 0);
    sb.delete();
    exc_at = 0;

    // 4: vstart == vl -> no micro-ops, completion right after acceptance
    start_op(5, 5, 0, 0);
    wait_done(10);
    check("t4_done_cycle", done_cyc, acc_cyc);
    check("t4_fires", fires, 0);
    check("t4_done_exc", done_exc, 0);

    // 5: vd wraps mod 32; latency 3 keeps 3 credits steady with simultaneous fire+resp
    lat = 3;
    start_op(0, 1, 7, 30);
    wait_done(40);
    check("t5_fires", fires, 8);
    check("t5_no_stall", last_fire - first_fire, 7);
    check("t5_done_exc", done_exc, 0);
    check("t5_sb_empty", sb.size(), 0);

    // 6: reset mid-ISSUE with 3 outstanding
    auto_resp = 0;
    start_op(0, 8, 0, 0);
    repeat (3) tick();
    check("t6_fires", fires, 3);
    #2 rst_n = 1'b0;
    #1;
    check_idle("t6_async");
    @(posedge clk);
    #1;
    check_idle("t6_edge");
    #2 rst_n = 1'b1;
    sb.delete();
    due.delete();
    done_cnt = 0;
    repeat (4) tick();
    check("t6_no_done", done_cnt, 0);
    check("t6_start_ready", start_ready, 1);
    check("t6_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
